// File: rtl/arm7tdmi_ice_chain2.sv
// EmbeddedICE scan chain 2: serial access to the ICE register bus from the TCK domain.
// Optional macro ICE_CHAIN2_PEND_FLAG_EN: captured MSB flags a pending or aborted read.
module arm7tdmi_ice_chain2 #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int RD_TIMEOUT = 15
) (
    input  logic              tck,
    input  logic              trst_n,
    input  logic              tdi,
    input  logic              chain_sel,
    input  logic              capture_dr,
    input  logic              shift_dr,
    input  logic              update_dr,
    output logic              ice_tdo,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_rvalid,
    output logic              rd_timeout
);

    localparam int         SR_W    = DATA_W + ADDR_W + 1;
    localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

    typedef enum logic {IDLE, RD_PEND} state_t;

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [DATA_W-1:0] rd_hold, rd_hold_nxt;
    logic              rd_timeout_nxt;
    logic [SR_W-1:0]   sr;

    logic do_update, do_capture, do_shift;
    logic upd_write, upd_read, cap_flag;

    // Strobe priority only matters for illegal TAP sequences: update > capture > shift.
    assign do_update  = chain_sel & update_dr;
    assign do_capture = chain_sel & capture_dr & ~update_dr;
    assign do_shift   = chain_sel & shift_dr & ~capture_dr & ~update_dr;
    assign upd_write  = do_update &  sr[SR_W-1];
    assign upd_read   = do_update & ~sr[SR_W-1];

`ifdef ICE_CHAIN2_PEND_FLAG_EN
    assign cap_flag = (state == RD_PEND) | rd_timeout;
`else
    assign cap_flag = 1'b0;
`endif

    assign ice_tdo = sr[0];

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt      = state;
        cnt_nxt        = cnt;
        rd_hold_nxt    = rd_hold;
        rd_timeout_nxt = rd_timeout;
        case (state)
            IDLE: ;
            RD_PEND: begin
                if (reg_rvalid) begin
                    rd_hold_nxt    = reg_rdata;
                    cnt_nxt        = '0;
                    rd_timeout_nxt = 1'b0;
                    state_nxt      = IDLE;
                end else if (cnt == TO_LAST) begin
                    rd_hold_nxt    = '0;
                    cnt_nxt        = '0;
                    rd_timeout_nxt = 1'b1;
                    state_nxt      = IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
        endcase
        // A fresh read restarts the wait; an older late rvalid then counts for it.
        if (upd_read) begin
            state_nxt = RD_PEND;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_hold    <= '0;
            rd_timeout <= 1'b0;
            sr         <= '0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_wr     <= 1'b0;
            reg_rd     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rd_hold    <= rd_hold_nxt;
            rd_timeout <= rd_timeout_nxt;
            reg_wr     <= upd_write;
            reg_rd     <= upd_read;
            if (do_update) begin
                reg_addr <= sr[DATA_W +: ADDR_W];
                if (sr[SR_W-1]) reg_wdata <= sr[DATA_W-1:0];
            end
            if (do_capture)
                sr <= {cap_flag, reg_addr, rd_hold};
            else if (do_shift)
                sr <= {tdi, sr[SR_W-1:1]};
        end
    end

endmodule
